// File: rtl/cost_table_arbiter_pkg.sv
// Shared widths and lock-state encoding for the cost table arbiter family.
package cost_table_arbiter_pkg;

    localparam int ADDR_W  = 3;   // worker / job index width
    localparam int COST_W  = 7;   // cost word width
    localparam int MAX_REQ = 4;   // largest supported requester count

    // IDLE: arbitrate among all requesters; LOCKED: owner holds the port
    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } lock_state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin priority encoder: scans from ptr upward,
// wrapping to 0, and returns the first requester found as a one-hot vector.
module rr_pick #(
    parameter int N     = 2,
    parameter int PTR_W = 1
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     winner,
    output logic             valid
);

    // Two passes: first the indices at or above ptr, then the wrapped ones below it
    always_comb begin
        // NOTE: every output gets a default before any branch so no latch is inferred.
        winner = '0;
        valid  = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!valid && req[k] && (PTR_W'(k) >= ptr)) begin
                winner[k] = 1'b1;
                valid     = 1'b1;
            end
        end
        for (int k = 0; k < N; k++) begin
            if (!valid && req[k]) begin
                winner[k] = 1'b1;
                valid     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cost_table_arbiter.sv
// Shares one W/J -> Cost lookup port between NREQ evaluators. Whole bursts
// are granted atomically; bursts rotate round-robin between requesters.
module cost_table_arbiter
    import cost_table_arbiter_pkg::*;
#(
    parameter int NREQ = 2
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ-1:0]          req_last,
    input  logic [ADDR_W*NREQ-1:0]   req_w,
    input  logic [ADDR_W*NREQ-1:0]   req_j,
    output logic [NREQ-1:0]          gnt,
    output logic [NREQ-1:0]          rvalid,
    output logic [COST_W-1:0]        rdata,
    output logic [ADDR_W-1:0]        W,
    output logic [ADDR_W-1:0]        J,
    input  logic [COST_W-1:0]        Cost,
    output logic                     busy
);

    localparam int PTR_W = (NREQ > 2) ? 2 : 1;

    lock_state_t        state, state_nxt;
    logic [NREQ-1:0]    owner, owner_nxt;
    logic [PTR_W-1:0]   ptr, ptr_nxt;
    logic [PTR_W-1:0]   gnt_ptr;
    logic [NREQ-1:0]    win;
    logic               win_valid;
    logic               gnt_last;
    logic [ADDR_W-1:0]  w_sel, j_sel;

    rr_pick #(
        .N     (NREQ),
        .PTR_W (PTR_W)
    ) u_rr_pick (
        .req    (req),
        .ptr    (ptr),
        .winner (win),
        .valid  (win_valid)
    );

    // Grant, address mux and lock FSM next-state
    always_comb begin
        gnt       = '0;
        state_nxt = state;
        owner_nxt = owner;
        ptr_nxt   = ptr;
        gnt_ptr   = ptr;
        w_sel     = W;
        j_sel     = J;

        // No grants while reset is held; a locked owner alone may be granted
        if (!RST) begin
            if (state == IDLE) begin
                if (win_valid) gnt = win;
            end else begin
                gnt = req & owner;
            end
        end

        gnt_last = |(gnt & req_last);

        // Address of the granted requester and the pointer just past it
        for (int k = 0; k < NREQ; k++) begin
            if (gnt[k]) begin
                w_sel   = req_w[ADDR_W*k +: ADDR_W];
                j_sel   = req_j[ADDR_W*k +: ADDR_W];
                gnt_ptr = (k == NREQ - 1) ? '0 : PTR_W'(k + 1);
            end
        end

        case (state)
            IDLE: begin
                if (|gnt) begin
                    if (gnt_last) begin
                        ptr_nxt = gnt_ptr;
                    end else begin
                        state_nxt = LOCKED;
                        owner_nxt = gnt;
                    end
                end
            end
            LOCKED: begin
                if ((|gnt) && gnt_last) begin
                    state_nxt = IDLE;
                    owner_nxt = '0;
                    ptr_nxt   = gnt_ptr;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Lock state, pointer and lookup registers
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state  <= IDLE;
            owner  <= '0;
            ptr    <= '0;
            W      <= '0;
            J      <= '0;
            rvalid <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state  <= state_nxt;
            owner  <= owner_nxt;
            ptr    <= ptr_nxt;
            W      <= w_sel;
            J      <= j_sel;
            rvalid <= gnt;
        end
    end

    assign busy  = (state == LOCKED);
    assign rdata = Cost;

endmodule

// File: tb/tb_cost_table_arbiter.sv
// Directed bench for cost_table_arbiter with NREQ=2 and NREQ=3 instances;
// responses are predicted into per-instance queues and compared one cycle later.
module tb_cost_table_arbiter;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // NREQ=2 instance
    logic [1:0] req2, last2, gnt2, rvalid2;
    logic [5:0] w2, j2;
    logic [6:0] rdata2, cost2;
    logic [2:0] W2, J2;
    logic       busy2;

    // NREQ=3 instance
    logic [2:0] req3, last3, gnt3, rvalid3;
    logic [8:0] w3, j3;
    logic [6:0] rdata3, cost3;
    logic [2:0] W3, J3;
    logic       busy3;

    typedef struct {
        logic [3:0] rv;
        logic [6:0] data;
    } resp_t;

    resp_t sb2[$];
    resp_t sb3[$];
    int n_assert = 0;
    int n_fail   = 0;

    // Known cost table: each (w,j) maps to a distinct 7-bit word
    function automatic logic [6:0] tbl(input logic [2:0] w, input logic [2:0] j);
        return {w, j, w[0] ^ j[0]};
    endfunction

    assign cost2 = tbl(W2, J2);
    assign cost3 = tbl(W3, J3);

    cost_table_arbiter #(.NREQ(2)) dut2 (
        .CLK(clk), .RST(rst), .req(req2), .req_last(last2), .req_w(w2), .req_j(j2),
        .gnt(gnt2), .rvalid(rvalid2), .rdata(rdata2), .W(W2), .J(J2), .Cost(cost2), .busy(busy2)
    );

    cost_table_arbiter #(.NREQ(3)) dut3 (
        .CLK(clk), .RST(rst), .req(req3), .req_last(last3), .req_w(w3), .req_j(j3),
        .gnt(gnt3), .rvalid(rvalid3), .rdata(rdata3), .W(W3), .J(J3), .Cost(cost3), .busy(busy3)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_resp2(input string tag);
        resp_t e;
        if (sb2.size() == 0) begin
            chk({tag, ":sb2_empty"}, 32'(sb2.size()), 32'd1);
            return;
        end
        e = sb2.pop_front();
        chk({tag, ":rvalid"}, 32'(rvalid2), 32'(e.rv[1:0]));
        if (e.rv != 4'd0) chk({tag, ":rdata"}, 32'(rdata2), 32'(e.data));
    endtask

    task automatic check_resp3(input string tag);
        resp_t e;
        if (sb3.size() == 0) begin
            chk({tag, ":sb3_empty"}, 32'(sb3.size()), 32'd1);
            return;
        end
        e = sb3.pop_front();
        chk({tag, ":rvalid"}, 32'(rvalid3), 32'(e.rv[2:0]));
        if (e.rv != 4'd0) chk({tag, ":rdata"}, 32'(rdata3), 32'(e.data));
    endtask

    // One cycle on the NREQ=2 instance; entered and left at posedge+1
    task automatic step2(input logic [1:0] rq, input logic [1:0] lst, input logic [5:0] w,
                         input logic [5:0] j, input logic [1:0] eg, input logic eb,
                         input string tag);
        resp_t p;
        req2 = rq; last2 = lst; w2 = w; j2 = j;
        @(negedge clk);
        chk({tag, ":gnt"}, 32'(gnt2), 32'(eg));
        if (eb !== 1'bx) chk({tag, ":busy"}, 32'(busy2), 32'(eb));
        check_resp2(tag);
        p.rv = {2'b00, eg};
        p.data = '0;
        for (int k = 0; k < 2; k++)
            if (eg[k]) p.data = tbl(w[3*k +: 3], j[3*k +: 3]);
        sb2.push_back(p);
        @(posedge clk); #1;
    endtask

    task automatic step3(input logic [2:0] rq, input logic [2:0] lst, input logic [8:0] w,
                         input logic [8:0] j, input logic [2:0] eg, input string tag);
        resp_t p;
        req3 = rq; last3 = lst; w3 = w; j3 = j;
        @(negedge clk);
        chk({tag, ":gnt"}, 32'(gnt3), 32'(eg));
        chk({tag, ":busy"}, 32'(busy3), 32'd0);
        check_resp3(tag);
        p.rv = {1'b0, eg};
        p.data = '0;
        for (int k = 0; k < 3; k++)
            if (eg[k]) p.data = tbl(w[3*k +: 3], j[3*k +: 3]);
        sb3.push_back(p);
        @(posedge clk); #1;
    endtask

    // Async reset pulse placed between edges; entered and left at posedge+1
    task automatic pulse_reset(input string tag);
        #2 rst = 1'b1;
        #1;
        chk({tag, ":rvalid"}, 32'(rvalid2), 32'd0);
        chk({tag, ":busy"}, 32'(busy2), 32'd0);
        chk({tag, ":gnt"}, 32'(gnt2), 32'd0);
        chk({tag, ":W"}, 32'(W2), 32'd0);
        chk({tag, ":J"}, 32'(J2), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        sb2.delete();
        sb2.push_back('{rv: 4'd0, data: 7'd0});
    endtask

    logic [2:0] jt [8];

    initial begin
        jt = '{3'd3, 3'd5, 3'd1, 3'd0, 3'd7, 3'd2, 3'd6, 3'd4};

        // Reset with requests pending: nothing may be granted
        rst = 1'b1;
        req2 = 2'b11; last2 = 2'b00; w2 = 6'o75; j2 = 6'o64;
        req3 = 3'b111; last3 = 3'b111; w3 = '0; j3 = '0;
        #3;
        chk("rst:gnt2", 32'(gnt2), 32'd0);
        chk("rst:gnt3", 32'(gnt3), 32'd0);
        chk("rst:W", 32'(W2), 32'd0);
        chk("rst:J", 32'(J2), 32'd0);
        chk("rst:rvalid", 32'(rvalid2), 32'd0);
        chk("rst:busy", 32'(busy2), 32'd0);
        @(posedge clk); #1;
        chk("rst_hold:gnt2", 32'(gnt2), 32'd0);
        req2 = 2'b00; req3 = 3'b000;
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
        sb2.push_back('{rv: 4'd0, data: 7'd0});

        // Single requester, 8-lookup burst
        for (int i = 0; i < 8; i++)
            step2(2'b01, (i == 7) ? 2'b01 : 2'b00, {3'd0, 3'(i)}, {3'd0, jt[i]},
                  2'b01, (i == 0) ? 1'b0 : 1'b1, "burst8");
        step2(2'b00, 2'b00, 6'd0, 6'd0, 2'b00, 1'b0, "burst8_end");

        // Both request from reset; requester 0 bursts 4, requester 1 follows with no bubble
        pulse_reset("rst_pulse");
        for (int i = 0; i < 4; i++)
            step2(2'b11, (i == 3) ? 2'b01 : 2'b00, {3'd6, 3'(i)}, {3'd2, 3'(7 - i)},
                  2'b01, (i == 0) ? 1'b0 : 1'b1, "both_r0");
        step2(2'b11, 2'b00, {3'd6, 3'd0}, {3'd2, 3'd1}, 2'b10, 1'b0, "both_r1a");
        step2(2'b11, 2'b10, {3'd7, 3'd0}, {3'd3, 3'd1}, 2'b10, 1'b1, "both_r1b");
        step2(2'b11, 2'b11, {3'd5, 3'd4}, {3'd1, 3'd2}, 2'b01, 1'b0, "both_ptr0");
        step2(2'b11, 2'b11, {3'd3, 3'd4}, {3'd6, 3'd2}, 2'b10, 1'b0, "both_ptr1");
        step2(2'b00, 2'b00, 6'd0, 6'd0, 2'b00, 1'b0, "both_end");

        // Lock stall: owner 0 pauses mid-burst while requester 1 waits
        for (int i = 0; i < 2; i++)
            step2(2'b01, 2'b00, {3'd0, 3'(i + 2)}, {3'd0, 3'(i)}, 2'b01,
                  (i == 0) ? 1'b0 : 1'b1, "stall_pre");
        for (int i = 0; i < 10; i++)
            step2(2'b10, 2'b10, {3'd4, 3'd0}, {3'd4, 3'd0}, 2'b00, 1'b1, "stall_hold");
        for (int i = 2; i < 8; i++)
            step2(2'b11, (i == 7) ? 2'b11 : 2'b10, {3'd4, 3'(i)}, {3'd4, 3'(7 - i)},
                  2'b01, 1'b1, "stall_resume");
        step2(2'b10, 2'b10, {3'd4, 3'd1}, {3'd4, 3'd2}, 2'b10, 1'b0, "stall_next");
        step2(2'b00, 2'b00, 6'd0, 6'd0, 2'b00, 1'b0, "stall_end");

        // Reset during lookup 3 of requester 1's burst
        step2(2'b10, 2'b00, {3'd5, 3'd0}, {3'd4, 3'd0}, 2'b10, 1'b0, "mid_l1");
        step2(2'b10, 2'b00, {3'd2, 3'd0}, {3'd6, 3'd0}, 2'b10, 1'b1, "mid_l2");
        req2 = 2'b10; last2 = 2'b00; w2 = {3'd7, 3'd0}; j2 = {3'd7, 3'd0};
        @(negedge clk);
        chk("mid_l3:gnt", 32'(gnt2), 32'd2);
        check_resp2("mid_l3");
        #2 rst = 1'b1;
        #1;
        chk("mid_rst:rvalid", 32'(rvalid2), 32'd0);
        chk("mid_rst:busy", 32'(busy2), 32'd0);
        chk("mid_rst:gnt", 32'(gnt2), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        sb2.delete();
        sb2.push_back('{rv: 4'd0, data: 7'd0});
        step2(2'b11, 2'b11, {3'd1, 3'd6}, {3'd2, 3'd5}, 2'b01, 1'b0, "mid_after");
        step2(2'b00, 2'b00, 6'd0, 6'd0, 2'b00, 1'b0, "mid_end");

        // NREQ=3: continuous single-lookup bursts rotate 0,1,2 with wrap
        sb3.delete();
        sb3.push_back('{rv: 4'd0, data: 7'd0});
        for (int i = 0; i < 6; i++)
            step3(3'b111, 3'b111, {3'(i + 2), 3'(i + 1), 3'(i)}, {3'(7 - i), 3'(i), 3'(i + 3)},
                  3'b001 << (i % 3), "wrap3");
        step3(3'b000, 3'b000, 9'd0, 9'd0, 3'b000, "wrap3_end");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/cost_table_arbiter.md
# cost_table_arbiter

Shares the single Cost lookup port (W/J address out, 7-bit Cost back) between several job-assignment evaluators, so multiple permutation engines can run concurrently against one cost table. Grants whole bursts (one permutation = up to 8 lookups) atomically with round-robin fairness between bursts. Sits between the evaluators and the cost table in the job-assignment top level.

## Interface
- NREQ, default 2: number of requesters (2..4).
- CLK  in  1: system clock, rising edge.
- RST  in  1: reset, asynchronous, active-high.
- req  in  NREQ: requester k wants a lookup this cycle.
- req_last  in  NREQ: this lookup ends requester k's burst.
- req_w  in  3*NREQ: worker index per requester (slice k = bits 3k+2:3k).
- req_j  in  3*NREQ: job index per requester.
- gnt  out  NREQ: one-hot, combinational; lookup of requester k accepted this cycle.
- rvalid  out  NREQ: one-hot, registered; rdata is the answer to requester k's lookup granted last cycle.
- rdata  out  7: Cost passed through, shared by all requesters.
- W  out  3: registered worker address to cost table.
- J  out  3: registered job address to cost table.
- Cost  in  7: table data for the W/J currently presented (combinational table).
- busy  out  1: a burst is locked (owner valid).

## Operation
- State: owner (NREQ-bit one-hot or none), locked flag, rr pointer (index of highest-priority requester), W, J, rvalid.
- States: IDLE (locked=0), LOCKED (locked=1, owner fixed).
- IDLE: winner = first k with req[k]=1 scanning ptr, ptr+1, ... mod NREQ. gnt[winner]=1. If req_last[winner]=0 -> LOCKED with owner=winner; else stay IDLE and ptr <= winner+1 mod NREQ.
- LOCKED: only owner can be granted; gnt[owner]=req[owner]. Other requests ignored (not queued). On owner grant with req_last=1 -> IDLE, ptr <= owner+1 mod NREQ.
- Owner dropping req mid-burst: lock held indefinitely, no grants to anyone; only req_last or RST releases.
- On any grant: W <= req_w slice, J <= req_j slice, rvalid <= gnt. With no grant: W/J hold, rvalid <= 0.
- rdata = Cost, unregistered; meaningful only when some rvalid bit set.
- Requester holds req/req_w/req_j until it sees gnt; req_last sampled only on granted cycles.
- No arithmetic; ptr wraps modulo NREQ (for NREQ=3, 2 -> 0).

## Timing
- Reset values: W=0, J=0, gnt=0 (no req while RST), rvalid=0, busy=0, ptr=0, locked=0.
- RST asserted mid-burst: lock, owner, rvalid cleared immediately; in-flight response is lost; requesters must restart their burst.
- Grant in cycle t (gnt high, combinational from req) -> W/J updated at edge ending t -> rvalid[k] and rdata valid during t+1. Latency 1 cycle.
- Back-to-back: owner may issue a lookup every cycle; throughput 1 lookup/cycle sustained.
- Burst end and next burst: last grant in cycle t, new winner (possibly another requester) granted in t+1; no bubble.
- Single-lookup burst (req_last=1 on first grant) never enters LOCKED; busy stays 0.
- busy registered: rises the cycle after the first non-last grant, falls the cycle after the last grant.

## Structure
- Shared package: W/J width (3), cost width (7), max requesters (4), state encoding IDLE/LOCKED.
- One sub-module: rr_pick — combinational round-robin priority encoder (req vector + ptr in -> one-hot winner + valid out), reused by later arbiters.
- Top holds lock FSM, ptr, W/J/rvalid registers.

## Test plan
- Reset: RST pulse asynchronously between edges -> W=0, J=0, rvalid=0, busy=0 immediately; no gnt while RST high.
- Single requester, 8-lookup burst W=0..7, J=3,5,1,0,7,2,6,4 against known table -> gnt 8 consecutive cycles, rvalid[0] each following cycle, rdata equal to table entries in order, busy 1 then 0.
- NREQ=2, both request from reset, req_last on 4th lookup -> requester 0 gets 4 grants, requester 1 granted the very next cycle, ptr then favours 0 only after 1's burst ends.
- Lock stall: requester 0 drops req after 2 of 8 lookups while requester 1 requests -> no gnt to 1 for 10 cycles; 0 resumes and finishes -> 1 granted cycle after 0's last.
- Reset mid-burst: RST during lookup 3 of requester 1 -> rvalid cleared, busy 0, after release requester 0 wins (ptr=0).
- NREQ=3 wrap: all three issue single-lookup bursts continuously -> grants rotate 0,1,2,0,1,2 with one grant per cycle.
